// File: rtl/counter_checker.sv
// counter_checker: watches a free-running counter and checks that each valid
// sample is the successor of the previous one. After LOCK_COUNT consecutive
// correct successors it declares lock. Once locked, any wrong value raises a
// one-cycle error pulse, bumps a saturating error counter and drops back to
// re-acquisition. Every output comes straight from a register.
module counter_checker #(
  parameter int WIDTH      = 2,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             valid_in,
  input  logic             clear_in,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] error_count,
  output logic [WIDTH-1:0] expected
);

  // Match counter must be able to hold LOCK_COUNT itself.
  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0] ONE_V    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    ONE_M    = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    LOCK_M   = MW'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ONE_E    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    matchCnt_q, matchCnt_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             errPulse_q, errPulse_d;
  logic [ERR_W-1:0] errCount_q, errCount_d;
  logic [MW-1:0]    matchInc;
  logic [WIDTH-1:0] sampleNext;

  assign matchInc   = matchCnt_q + ONE_M;
  assign sampleNext = counter_in + ONE_V;

  // Next-state logic: walk the FSM on valid samples and maintain the error counter.
  always_comb begin
    state_d    = state_q;
    matchCnt_d = matchCnt_q;
    expected_d = expected_q;
    errPulse_d = 1'b0;
    errCount_d = errCount_q;

    if (valid_in) begin
      case (state_q)
        UNLOCKED: begin
          expected_d = sampleNext;
          matchCnt_d = '0;
          state_d    = ACQUIRE;
        end
        ACQUIRE: begin
          if (counter_in == expected_q) begin
            matchCnt_d = matchInc;
            expected_d = expected_q + ONE_V;
            if (matchInc == LOCK_M) begin
              state_d = LOCKED;
            end
          end else begin
            expected_d = sampleNext;
            matchCnt_d = '0;
          end
        end
        LOCKED: begin
          if (counter_in == expected_q) begin
            expected_d = expected_q + ONE_V;
          end else begin
            errPulse_d = 1'b1;
            expected_d = sampleNext;
            matchCnt_d = '0;
            state_d    = ACQUIRE;
            if (errCount_q != ERR_MAX) begin
              errCount_d = errCount_q + ONE_E;
            end
          end
        end
        default: begin
          state_d    = UNLOCKED;
          matchCnt_d = '0;
          expected_d = '0;
        end
      endcase
    end

    // A clear wins over a same-cycle increment but leaves the FSM alone.
    if (clear_in) begin
      errCount_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= UNLOCKED;
      matchCnt_q <= '0;
      expected_q <= '0;
      errPulse_q <= 1'b0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      matchCnt_q <= matchCnt_d;
      expected_q <= expected_d;
      errPulse_q <= errPulse_d;
      errCount_q <= errCount_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error_pulse = errPulse_q;
  assign error_count = errCount_q;
  assign expected    = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed testbench for counter_checker (WIDTH=2, LOCK_COUNT=3, ERR_W=2).
module tb_counter_checker;

  logic       clk;
  logic       reset;
  logic [1:0] counterIn;
  logic       validIn;
  logic       clearIn;
  logic       locked;
  logic       errorPulse;
  logic [1:0] errorCount;
  logic [1:0] expectedOut;

  int errors;
  int checks;
  logic [1:0] modelExp;

  counter_checker #(
    .WIDTH(2),
    .LOCK_COUNT(3),
    .ERR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .counter_in(counterIn),
    .valid_in(validIn),
    .clear_in(clearIn),
    .locked(locked),
    .error_pulse(errorPulse),
    .error_count(errorCount),
    .expected(expectedOut)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] wanted);
    checks = checks + 1;
    if (observed !== wanted) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, wanted);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic applyStimulus(input logic valid, input logic [1:0] value,
                               input logic clr);
    validIn   = valid;
    counterIn = value;
    clearIn   = clr;
    @(posedge clk);
    #1;
  endtask

  // Check all four outputs at once.
  task automatic checkAll(input string tag, input logic lck, input logic pls,
                          input logic [1:0] cnt, input logic [1:0] exv);
    checkOutput({tag, ".locked"},   32'(locked),      32'(lck));
    checkOutput({tag, ".pulse"},    32'(errorPulse),  32'(pls));
    checkOutput({tag, ".count"},    32'(errorCount),  32'(cnt));
    checkOutput({tag, ".expected"}, 32'(expectedOut), 32'(exv));
  endtask

  // From a locked state with expectation modelExp: inject one wrong sample,
  // then relock with three correct successors.
  task automatic errorAndRelock(input string tag, input logic [1:0] cntAfter,
                                input logic clr);
    logic [1:0] bad;
    bad = modelExp + 2'd2;
    applyStimulus(1'b1, bad, clr);
    checkAll({tag, ".err"}, 1'b0, 1'b1, cntAfter, bad + 2'd1);
    applyStimulus(1'b1, bad + 2'd1, 1'b0);
    checkOutput({tag, ".pulseFall"}, 32'(errorPulse), 32'd0);
    applyStimulus(1'b1, bad + 2'd2, 1'b0);
    applyStimulus(1'b1, bad + 2'd3, 1'b0);
    checkAll({tag, ".relock"}, 1'b1, 1'b0, cntAfter, bad);
    modelExp = bad;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    validIn   = 1'b0;
    clearIn   = 1'b0;
    counterIn = 2'd0;

    // Reset state
    applyStimulus(1'b1, 2'd2, 1'b1);
    applyStimulus(1'b1, 2'd3, 1'b0);
    checkAll("reset", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b1;

    // Acquisition 0,1,2,3
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkAll("acq0", 1'b0, 1'b0, 2'd0, 2'd1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkAll("acq1", 1'b0, 1'b0, 2'd0, 2'd2);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkAll("acq2", 1'b0, 1'b0, 2'd0, 2'd3);
    applyStimulus(1'b1, 2'd3, 1'b0);
    checkAll("acq3", 1'b1, 1'b0, 2'd0, 2'd0);

    // Wrap-around while locked: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0);
      checkAll($sformatf("wrap%0d", i), 1'b1, 1'b0, 2'd0, 2'(i + 1));
    end

    // Error with expected=1: sample 3, then relock with 0,1,2
    applyStimulus(1'b1, 2'd3, 1'b0);
    checkAll("err", 1'b0, 1'b1, 2'd1, 2'd0);
    applyStimulus(1'b1, 2'd0, 1'b0);
    checkAll("relock0", 1'b0, 1'b0, 2'd1, 2'd1);
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkAll("relock1", 1'b0, 1'b0, 2'd1, 2'd2);
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkAll("relock2", 1'b1, 1'b0, 2'd1, 2'd3);

    // Valid gating: four idle cycles with a wandering counter
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkAll("gate0", 1'b1, 1'b0, 2'd1, 2'd3);
    applyStimulus(1'b0, 2'd2, 1'b0);
    checkAll("gate1", 1'b1, 1'b0, 2'd1, 2'd3);
    applyStimulus(1'b0, 2'd1, 1'b0);
    checkAll("gate2", 1'b1, 1'b0, 2'd1, 2'd3);
    applyStimulus(1'b0, 2'd0, 1'b0);
    checkAll("gate3", 1'b1, 1'b0, 2'd1, 2'd3);

    // Clear alone leaves the FSM untouched
    applyStimulus(1'b0, 2'd1, 1'b1);
    checkAll("clear", 1'b1, 1'b0, 2'd0, 2'd3);

    // Saturation: five errors -> 1,2,3,3,3; sixth with clear -> 0
    modelExp = 2'd3;
    errorAndRelock("sat1", 2'd1, 1'b0);
    errorAndRelock("sat2", 2'd2, 1'b0);
    errorAndRelock("sat3", 2'd3, 1'b0);
    errorAndRelock("sat4", 2'd3, 1'b0);
    errorAndRelock("sat5", 2'd3, 1'b0);
    errorAndRelock("sat6clr", 2'd0, 1'b1);

    // Mid-operation reset while locked with error_count=2
    errorAndRelock("pre1", 2'd1, 1'b0);
    errorAndRelock("pre2", 2'd2, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, modelExp + 2'd2, 1'b0);
    checkAll("midReset", 1'b0, 1'b0, 2'd0, 2'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b0);
    checkAll("postReset", 1'b0, 1'b0, 2'd0, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
